packet_framer_tx: RTL and testbench
===================================

// Module: packet_framer_tx
// PURPOSE
//   Parametrised serial frame transmitter for NoC links. Second-generation byte framer.
//   Accepts a flat packet vector over a valid/ready handshake and emits a byte-stuffed frame:
//   FLAG, escaped data bytes MSB-first, optional escaped CRC-8 trailer, FLAG.
//   Honours downstream backpressure. Accepts the next packet during the closing FLAG,
//   so back-to-back frames have no idle gap. Sits between the router egress and the link PHY.
// PARAMETERS
//   PKT_BYTES  default PKT_SIZE_BYTES  data bytes per frame; must be >= 1
//   CRC_EN     default 1               1: append CRC-8 trailer; 0: no trailer
//   CNT_W      default 16              width of the frame_count output
// PORTS
//   clk          in   1              system clock
//   rst_n        in   1              asynchronous, active-low reset
//   in_valid     in   1              pkt_data is valid
//   in_ready     out  1              framer accepts pkt_data this cycle
//   pkt_data     in   PKT_BYTES*8    {x_dest,y_dest,payload} packed by caller; MSB byte sent first
//   tx_byte      out  8              serial output byte
//   tx_valid     out  1              tx_byte is valid
//   tx_ready     in   1              sink consumes tx_byte this cycle
//   busy         out  1              a frame is in progress (state != S_IDLE)
//   frame_count  out  CNT_W          closing FLAGs accepted; wraps modulo 2**CNT_W
// BEHAVIOUR
//   Reset and idle outputs
//   - All state is reset asynchronously while rst_n = 0:
//     state = S_IDLE, byte index = 0, crc = 8'h00, data register = 0, frame_count = 0.
//   - in_ready = 0 while rst_n = 0.
//   - tx_valid = 0 and tx_byte = 8'h00 in S_IDLE.
//   Handshakes
//   - Input handshake fires when in_valid & in_ready. pkt_data is latched on that edge.
//   - Output beat fires when tx_valid & tx_ready. tx_byte is an advance of state only on a beat.
//   - While tx_valid & !tx_ready: tx_byte, state, index and crc hold unchanged.
//   - in_ready = (state == S_IDLE) | (state == S_END & tx_ready).
//   Latency
//   - Handshake in cycle N: FLAG 8'h7E is presented in cycle N+1.
//   - Data bytes never stall internally; only tx_ready stalls the frame.
//   State machine
//   - S_IDLE:
//       handshake -> S_START.
//   - S_START:
//       tx_byte = 8'h7E.
//       beat -> S_DATA, idx = 0, crc = 8'h00.
//   - S_DATA: cur = byte idx (MSB-first).
//       cur is 8'h7E or 8'h7D: tx_byte = 8'h7D; beat -> S_ESC.
//       otherwise: tx_byte = cur; beat -> crc update, idx++.
//         Next state is S_DATA; at the last byte (idx == PKT_BYTES-1) it is S_CRC if CRC_EN, else S_END.
//   - S_ESC:
//       tx_byte = cur ^ 8'h20.
//       beat -> crc update, idx++; next state as for S_DATA.
//   - S_CRC:
//       tx_byte = crc, or 8'h7D if crc is 8'h7E or 8'h7D.
//       beat -> S_CRC_ESC if escaped, else S_END.
//   - S_CRC_ESC:
//       tx_byte = crc ^ 8'h20.
//       beat -> S_END.
//   - S_END:
//       tx_byte = 8'h7E.
//       beat -> frame_count++.
//       Next state is S_START if an input handshake fires in the same cycle, else S_IDLE.
//   Arithmetic
//   - CRC-8: polynomial 0x07, init 8'h00, no reflection, no final XOR.
//   - CRC is computed over the unescaped data bytes only.
//   - idx width is $clog2(PKT_BYTES), minimum 1 bit. Slicing uses [PKT_BYTES*8-1 - idx*8 -: 8].
//   Boundary conditions
//   - PKT_BYTES = 1: S_START -> S_DATA -> S_CRC/S_END.
//   - in_valid in a non-accepting state is ignored; pkt_data is not sampled.
//   - tx_ready low for an arbitrary number of cycles in any state: no byte is lost or duplicated.
//   - rst_n asserted mid-frame: frame aborts immediately, with no closing FLAG.
//     tx_valid drops asynchronously. The next frame starts clean.
// STRUCTURE
//   - noc_params package holds:
//       FLAG_BYTE = 8'h7E, ESC_BYTE = 8'h7D, ESC_XOR = 8'h20,
//       the framer state enum, and function crc8_next(crc, byte).
//     The receive-side deframer shares these.
//   - Single module with one state register and one datapath; no sub-module.
//     crc8_next is a package function.
// TESTING
//   - T1, escaping with CRC: PKT_BYTES=4, CRC_EN=1, pkt_data = 32'h127E347D, tx_ready = 1.
//     Required output: 7E 12 7D 5E 34 7D 5D D9 7E. frame_count = 1.
//   - T2, no CRC: same packet, CRC_EN=0.
//     Required output: 7E 12 7D 5E 34 7D 5D 7E. in_ready = 0 from START through the last data byte.
//   - T3, backpressure: T1 with tx_ready toggling at random, including 5-cycle stalls on S_ESC and S_CRC.
//     Required: beat sequence identical to T1; tx_byte stable across every stall.
//   - T4, back-to-back: two packets, in_valid held high, tx_ready = 1.
//     Required: second FLAG immediately follows the first closing FLAG, no idle cycle; frame_count = 2.
//   - T5, reset mid-frame: deassert rst_n after the second data byte.
//     Required: tx_valid = 0 at once; after release, packet 32'h01020304 gives 7E 01 02 03 04 <crc> 7E.
//   - T6, CRC needs escaping: pick a packet whose CRC is 8'h7E.
//     Required: tx_byte sequence ... 7D 5E 7E at the end of the frame.

Source files
------------

// File: rtl/noc_params.sv
`default_nettype none
// ============================================================================
// noc_params
//   Shared NoC link constants: framing bytes, framer state encoding and the
//   CRC-8 (poly 0x07) byte update used by both framer and deframer.
//   Revision: 1.0 - initial release
// ============================================================================
package noc_params;

  // Default number of data bytes per frame ({x_dest, y_dest, payload}).
  localparam int PKT_SIZE_BYTES = 4;

  localparam logic [7:0] FLAG_BYTE = 8'h7E;
  localparam logic [7:0] ESC_BYTE  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  // Framer state encoding.
  typedef logic [2:0] framer_state_t;
  localparam framer_state_t S_IDLE    = 3'd0;
  localparam framer_state_t S_START   = 3'd1;
  localparam framer_state_t S_DATA    = 3'd2;
  localparam framer_state_t S_ESC     = 3'd3;
  localparam framer_state_t S_CRC     = 3'd4;
  localparam framer_state_t S_CRC_ESC = 3'd5;
  localparam framer_state_t S_END     = 3'd6;

  // CRC-8, polynomial x^8+x^2+x+1, MSB-first, no reflection, no final XOR.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data_byte);
    logic [7:0] c;
    c = crc ^ data_byte;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage : noc_params
`default_nettype wire

// File: rtl/packet_framer_tx.sv
`default_nettype none
// ============================================================================
// packet_framer_tx
//   Byte-stuffed frame transmitter: FLAG, escaped data bytes MSB-first,
//   optional escaped CRC-8 trailer, FLAG. Accepts the next packet while the
//   closing FLAG is being consumed so back-to-back frames have no gap.
//   Revision: 1.0 - initial release
// ============================================================================
module packet_framer_tx
  import noc_params::*;
#(
  parameter int PKT_BYTES = PKT_SIZE_BYTES,
  parameter bit CRC_EN    = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PKT_BYTES*8-1:0] pkt_data,
  output logic [7:0]             tx_byte,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [CNT_W-1:0]       frame_count
);

  localparam int DATA_W = PKT_BYTES * 8;
  localparam int IDX_W  = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

  framer_state_t     state;
  framer_state_t     state_nxt;
  framer_state_t     after_data;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [7:0]        crc;
  logic [7:0]        crc_nxt;
  logic [DATA_W-1:0] data;
  logic [CNT_W-1:0]  frame_cnt;
  logic [7:0]        cur;
  logic              cur_esc;
  logic              crc_esc;
  logic              beat;
  logic              hs;

  // Current data byte, MSB byte first.
  assign cur     = data[DATA_W-1 - 8*int'(idx) -: 8];
  assign cur_esc = (cur == FLAG_BYTE) || (cur == ESC_BYTE);
  assign crc_esc = (crc == FLAG_BYTE) || (crc == ESC_BYTE);

  // Where a completed data byte leads: next byte, trailer or closing FLAG.
  assign after_data = (idx != LAST_IDX) ? S_DATA : (CRC_EN ? S_CRC : S_END);

  // tx_valid follows the (asynchronously reset) state so it drops at once on reset.
  assign busy        = (state != S_IDLE);
  assign tx_valid    = busy;
  assign in_ready    = rst_n & ((state == S_IDLE) | ((state == S_END) & tx_ready));
  assign hs          = in_valid & in_ready;
  assign beat        = tx_valid & tx_ready;
  assign frame_count = frame_cnt;

  // Output byte selection and next-state / datapath update, advancing only on a beat.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    crc_nxt   = crc;
    tx_byte   = 8'h00;
    case (state)
      S_IDLE: begin
        if (hs) state_nxt = S_START;
      end
      S_START: begin
        tx_byte = FLAG_BYTE;
        if (beat) begin
          state_nxt = S_DATA;
          idx_nxt   = '0;
          crc_nxt   = 8'h00;
        end
      end
      S_DATA: begin
        if (cur_esc) begin
          tx_byte = ESC_BYTE;
          if (beat) state_nxt = S_ESC;
        end else begin
          tx_byte = cur;
          if (beat) begin
            crc_nxt   = crc8_next(crc, cur);
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = after_data;
          end
        end
      end
      S_ESC: begin
        tx_byte = cur ^ ESC_XOR;
        if (beat) begin
          crc_nxt   = crc8_next(crc, cur);
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = after_data;
        end
      end
      S_CRC: begin
        tx_byte = crc_esc ? ESC_BYTE : crc;
        if (beat) state_nxt = crc_esc ? S_CRC_ESC : S_END;
      end
      S_CRC_ESC: begin
        tx_byte = crc ^ ESC_XOR;
        if (beat) state_nxt = S_END;
      end
      S_END: begin
        tx_byte = FLAG_BYTE;
        if (beat) state_nxt = hs ? S_START : S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, index, CRC, packet latch and frame counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      crc       <= 8'h00;
      data      <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      crc   <= crc_nxt;
      if (hs) data <= pkt_data;
      if (beat && (state == S_END)) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule : packet_framer_tx
`default_nettype wire

// File: tb/tb_packet_framer_tx.sv
`default_nettype none
// ============================================================================
// tb_packet_framer_tx
//   Self-checking bench: frame-level scoreboard model plus directed frames
//   with hand-computed byte sequences. Instance 0 has CRC, instance 1 not.
//   Revision: 1.0 - initial release
// ============================================================================
module tb_packet_framer_tx;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [31:0]      pkt_data;
  logic             tx_ready;
  logic [1:0][7:0]  tx_byte;
  logic [1:0]       tx_valid;
  logic [1:0]       busy;
  logic [1:0][15:0] frame_count;

  always #5 clk = ~clk;

  packet_framer_tx #(.PKT_BYTES(4), .CRC_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .pkt_data(pkt_data), .tx_byte(tx_byte[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready), .busy(busy[0]), .frame_count(frame_count[0])
  );

  packet_framer_tx #(.PKT_BYTES(4), .CRC_EN(1'b0), .CNT_W(16)) dut_nc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .pkt_data(pkt_data), .tx_byte(tx_byte[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready), .busy(busy[1]), .frame_count(frame_count[1])
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q [2][$];
  bit         last_q[2][$];
  logic [7:0] obs   [2][$];
  int         fc_model[2];
  bit         prev_stall[2];
  logic [7:0] prev_byte[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=completion t=%0t", name, $time);
  endtask

  // Serial CRC-8, one bit at a time.
  function automatic logic [7:0] model_crc(input logic [31:0] p);
    logic [7:0] c = 8'h00;
    for (int b = 3; b >= 0; b--) begin
      for (int i = 7; i >= 0; i--) begin
        logic fb;
        fb = c[7] ^ p[8*b + i];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic push_stuffed(input int id, input logic [7:0] v);
    if (v == 8'h7E || v == 8'h7D) begin
      exp_q[id].push_back(8'h7D);      last_q[id].push_back(1'b0);
      exp_q[id].push_back(v ^ 8'h20);  last_q[id].push_back(1'b0);
    end else begin
      exp_q[id].push_back(v);          last_q[id].push_back(1'b0);
    end
  endtask

  // Expected wire bytes for one accepted packet.
  task automatic push_frame(input int id, input logic [31:0] p);
    exp_q[id].push_back(8'h7E); last_q[id].push_back(1'b0);
    for (int b = 3; b >= 0; b--) push_stuffed(id, p[8*b +: 8]);
    if (id == 0) push_stuffed(id, model_crc(p));
    exp_q[id].push_back(8'h7E); last_q[id].push_back(1'b1);
  endtask

  // Per-cycle comparison against the scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    for (int id = 0; id < 2; id++) begin
      if (!rst_n) begin
        chk("rst_tx_valid", tx_valid[id], 0);
        chk("rst_in_ready", in_ready[id], 0);
        chk("rst_frame_count", frame_count[id], 0);
        exp_q[id].delete();
        last_q[id].delete();
        fc_model[id]   = 0;
        prev_stall[id] = 1'b0;
      end else begin
        bit pend;
        bit exp_ir;
        pend   = (exp_q[id].size() != 0);
        exp_ir = !pend || (exp_q[id].size() == 1 && tx_ready);
        chk("tx_valid", tx_valid[id], pend);
        chk("busy", busy[id], pend);
        chk("in_ready", in_ready[id], exp_ir);
        chk("frame_count", frame_count[id], 16'(fc_model[id]));
        if (!tx_valid[id]) chk("idle_byte", tx_byte[id], 8'h00);
        if (prev_stall[id]) chk("stall_hold", tx_byte[id], prev_byte[id]);
        if (tx_valid[id] && tx_ready && pend) begin
          logic [7:0] e;
          bit         l;
          e = exp_q[id].pop_front();
          l = last_q[id].pop_front();
          chk("beat_byte", tx_byte[id], e);
          obs[id].push_back(tx_byte[id]);
          if (l) fc_model[id]++;
        end
        prev_stall[id] = tx_valid[id] && !tx_ready;
        prev_byte[id]  = tx_byte[id];
        if (in_valid[id] && in_ready[id]) push_frame(id, pkt_data);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int id, input logic [31:0] p, input bit keep);
    int n = 0;
    pkt_data     = p;
    in_valid[id] = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready[id]) break;
      n++;
      if (n > 60) begin
        timeout_fail("send_handshake");
        break;
      end
    end
    @(posedge clk); #1;
    if (!keep) in_valid[id] = 1'b0;
  endtask

  task automatic wait_done(input int id);
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy[id]) break;
      n++;
      if (n > 400) begin
        timeout_fail("frame_done");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_seq(input int id, input string name, input logic [7:0] req[$]);
    chk({name, "_len"}, obs[id].size(), req.size());
    for (int i = 0; i < req.size() && i < obs[id].size(); i++)
      chk(name, obs[id][i], req[i]);
  endtask

  logic [7:0] seq_t1[$];
  logic [7:0] seq_t2[$];
  logic [7:0] seq_t4[$];
  logic [7:0] seq_t5[$];
  logic [7:0] seq_t6[$];
  bit         t3_done;

  initial begin
    seq_t1 = '{8'h7E, 8'h12, 8'h7D, 8'h5E, 8'h34, 8'h7D, 8'h5D, 8'hD9, 8'h7E};
    seq_t2 = '{8'h7E, 8'h12, 8'h7D, 8'h5E, 8'h34, 8'h7D, 8'h5D, 8'h7E};
    seq_t4 = '{8'h7E, 8'h01, 8'h02, 8'h03, 8'h04, 8'hE3, 8'h7E,
               8'h7E, 8'h00, 8'h00, 8'h00, 8'h12, 8'h7D, 8'h5E, 8'h7E};
    seq_t5 = '{8'h7E, 8'h01, 8'h02, 8'h03, 8'h04, 8'hE3, 8'h7E};
    seq_t6 = '{8'h7E, 8'h00, 8'h00, 8'h00, 8'h12, 8'h7D, 8'h5E, 8'h7E};

    rst_n    = 1'b0;
    in_valid = 2'b00;
    pkt_data = 32'h0;
    tx_ready = 1'b1;
    t3_done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_byte", tx_byte[0], 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Model pins: CRC values computed by hand.
    chk("model_crc_t1", model_crc(32'h127E347D), 8'hD9);
    chk("model_crc_t6", model_crc(32'h00000012), 8'h7E);

    // T1: escaping with CRC.
    obs[0].delete();
    send(0, 32'h127E347D, 1'b0);
    wait_done(0);
    expect_seq(0, "t1_seq", seq_t1);
    chk("t1_frame_count", frame_count[0], 16'd1);

    // T2: no CRC trailer.
    obs[1].delete();
    send(1, 32'h127E347D, 1'b0);
    wait_done(1);
    expect_seq(1, "t2_seq", seq_t2);
    chk("t2_frame_count", frame_count[1], 16'd1);

    // T3: random backpressure with 5-cycle stalls on the escaped byte and CRC.
    obs[0].delete();
    fork
      begin
        send(0, 32'h127E347D, 1'b0);
        wait_done(0);
        t3_done = 1'b1;
      end
      begin
        int c3 = 0;
        int c7 = 0;
        while (!t3_done) begin
          @(posedge clk); #1;
          if (t3_done) break;
          if (obs[0].size() == 3 && c3 < 5) begin
            tx_ready = 1'b0; c3++;
          end else if (obs[0].size() == 7 && c7 < 5) begin
            tx_ready = 1'b0; c7++;
          end else begin
            tx_ready = 1'($urandom_range(0, 1));
          end
        end
      end
    join
    tx_ready = 1'b1;
    @(posedge clk); #1;
    expect_seq(0, "t3_seq", seq_t1);
    chk("t3_frame_count", frame_count[0], 16'd2);

    // T4: back-to-back frames with in_valid held high.
    obs[0].delete();
    send(0, 32'h01020304, 1'b1);
    send(0, 32'h00000012, 1'b0);
    wait_done(0);
    expect_seq(0, "t4_seq", seq_t4);
    chk("t4_frame_count", frame_count[0], 16'd4);

    // T6: CRC equal to FLAG gets escaped.
    obs[0].delete();
    send(0, 32'h00000012, 1'b0);
    wait_done(0);
    expect_seq(0, "t6_seq", seq_t6);
    chk("t6_frame_count", frame_count[0], 16'd5);

    // T5: reset asserted mid-frame after the second data byte.
    obs[0].delete();
    send(0, 32'h11223344, 1'b0);
    begin
      int n = 0;
      while (obs[0].size() < 3 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (obs[0].size() < 3) timeout_fail("t5_reach_data");
    end
    #2;
    chk("t5_pre_valid", tx_valid[0], 1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_drop", tx_valid[0], 0);
    chk("t5_in_ready", in_ready[0], 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    obs[0].delete();
    send(0, 32'h01020304, 1'b0);
    wait_done(0);
    expect_seq(0, "t5_seq", seq_t5);
    chk("t5_frame_count", frame_count[0], 16'd1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_packet_framer_tx
`default_nettype wire
